scfifo_ctrl: RTL and testbench
==============================

Name: scfifo_ctrl

Overview:
Control engine for the single-clock FIFO storage RAM (DWIDTH x 2**AWIDTH, one write port, one read port).
- Owns the write/read pointers, occupancy count and full/empty flags.
- Drives the RAM's wr_en/wr_addr/rd_en/rd_addr and compensates for its 1- or 2-cycle read latency.
- Emits a data-valid strobe aligned with RAM data_o.
- Sits between the producer/consumer request interface and the storage RAM; data never passes through this block.

Parameters:
- AWIDTH, 10, RAM address width; FIFO depth = 2**AWIDTH entries.
- RAM_LATENCY, 1, RAM read latency in cycles. 1 = unregistered RAM output; 2 = registered RAM output. Other values are illegal (elaboration-time $error).

Ports:
- clk_i  in  1  sole clock, rising edge.
- srst_i  in  1  synchronous active-high reset.
- wrreq_i  in  1  producer write request; data is presented to the RAM directly by the producer in the same cycle.
- rdreq_i  in  1  consumer read request.
- full_o  out  1  FIFO holds 2**AWIDTH entries.
- empty_o  out  1  FIFO holds 0 entries.
- usedw_o  out  AWIDTH+1  current occupancy, 0..2**AWIDTH.
- ram_wr_en_o  out  1  RAM write enable.
- ram_wr_addr_o  out  AWIDTH  RAM write address.
- ram_rd_en_o  out  1  RAM output-register enable.
- ram_rd_addr_o  out  AWIDTH  RAM read address.
- rd_valid_o  out  1  RAM data_o holds the word of an accepted read this cycle.

Behaviour:
- Reset (srst_i=1 at a clock edge): wr_ptr=0, rd_ptr=0, usedw_o=0, empty_o=1, full_o=0, rd_valid_o=0, latency pipe cleared, ram_wr_en_o=0, ram_rd_en_o=0. Reset mid-operation discards all contents and in-flight reads; rd_valid_o is 0 the cycle after reset.
- Write acceptance: wr_acc = wrreq_i & ~full_o, with one exception: when full and rdreq_i=1 in the same cycle, the write is also accepted.
- ram_wr_en_o = wr_acc (combinational); ram_wr_addr_o = wr_ptr. wr_ptr increments on wr_acc and wraps 2**AWIDTH-1 -> 0.
- Read acceptance: rd_acc = rdreq_i & ~empty_o. Empty with simultaneous wrreq: the write is accepted, the read is ignored (no fall-through).
- ram_rd_addr_o = rd_ptr (combinational). rd_ptr increments on rd_acc and wraps.
- Latency alignment:
  - RAM_LATENCY=1: ram_rd_en_o = rd_acc.
  - RAM_LATENCY=2: ram_rd_en_o = rd_acc delayed 1 cycle (registered). The address is presented in cycle t and the output register is enabled in t+1.
  - In both cases rd_valid_o = rd_acc delayed RAM_LATENCY cycles.
- Occupancy: usedw_o +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
  - full_o and empty_o are registered, derived from the next usedw value; never both 1.
- Full & rdreq & wrreq: both accepted and rd_ptr==wr_ptr. The RAM returns old data (read-before-write) at that address; this is required of the RAM and checked in the bench.
- Rejected requests (wr when full without rd, rd when empty) have no effect on state.
- Back-to-back reads at full rate are supported. rd_valid_o may be 1 on consecutive cycles.

Optional Feature:
SCFIFO_CTRL_ERR_FLAGS_EN:
- Defined: adds outputs ovf_o and udf_o (1 bit each), reset to 0.
  - ovf_o sets sticky on any rejected wrreq_i.
  - udf_o sets sticky on any rejected rdreq_i.
  - Both are cleared only by srst_i.
- Undefined: ports absent and no logic generated; all other behaviour is identical.

Decomposition:
- Package scfifo_pkg:
  - localparams for the legal RAM_LATENCY values (LAT_COMB=1, LAT_REG=2).
  - Function calc_next_usedw(usedw, wr_acc, rd_acc).
- Sub-module scfifo_rd_pipe (parameter DEPTH): a valid-bit shift register with synchronous clear, producing rd_valid_o and the delayed ram_rd_en_o. Instantiated once.

Test Plan:
- Reset, then 4 writes, then 4 reads (AWIDTH=3, RAM_LATENCY=1) -> usedw goes 1,2,3,4 then 3,2,1,0; rd_valid_o exactly 1 cycle after each rdreq; data order D0..D3; empty_o=1 at the end.
- Fill 8 entries (AWIDTH=3) -> full_o=1, usedw_o=8. A further wrreq -> ram_wr_en_o=0, usedw stays 8 (ovf_o=1 with macro). Then simultaneous wr+rd while full -> usedw stays 8, rd returns D0, wr_ptr and rd_ptr both advance.
- Empty FIFO, wrreq+rdreq together -> usedw_o=1, rd_valid_o never asserts, empty_o=0 next cycle (udf_o=1 with macro).
- RAM_LATENCY=2: read accepted at cycle t -> ram_rd_en_o=1 at t+1, rd_valid_o=1 at t+2; 3 back-to-back reads give 3 consecutive valid cycles carrying the correct words.
- Wrap: 20 write/read pairs through an 8-deep FIFO -> pointers wrap 7->0 with no data corruption; usedw_o never exceeds 8.
- srst_i asserted with usedw=5 and 2 reads in flight -> next cycle usedw_o=0, empty_o=1, rd_valid_o=0; subsequent write/read works from address 0.

Source files
------------

// File: rtl/scfifo_pkg.sv
// Shared definitions for the single-clock FIFO controller: the legal RAM read
// latencies and the occupancy update function.
package scfifo_pkg;

  // Legal RAM read latencies.
  localparam int unsigned LAT_COMB = 1;  // RAM output not registered
  localparam int unsigned LAT_REG  = 2;  // RAM output register present

  // Next occupancy. Simultaneous accepted write and read leave it unchanged.
  // Callers pass a zero-extended count and truncate the result to their width.
  function automatic logic [31:0] calc_next_usedw(logic [31:0] usedw,
                                                  logic        wr_acc,
                                                  logic        rd_acc);
    logic [31:0] nxt;
    nxt = usedw;
    case ({wr_acc, rd_acc})
      2'b10:   nxt = usedw + 32'd1;
      2'b01:   nxt = usedw - 32'd1;
      default: nxt = usedw;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/scfifo_rd_pipe.sv
// Valid-bit shift register with synchronous clear. valid_o is valid_i delayed
// DEPTH cycles; tap1_o is valid_i delayed one cycle.
module scfifo_rd_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic valid_i,
  output logic tap1_o,
  output logic valid_o
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  // Shift the accepted-read marker one stage per cycle.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = valid_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pipe state; reset drops every in-flight read.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tap1_o  = pipe_q[0];
  assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/scfifo_ctrl.sv
// Single-clock FIFO control engine: pointers, occupancy, full/empty flags, RAM
// port control and a read-data valid strobe aligned with the RAM's data_o.
// Optional sticky overflow/underflow flags (ovf_o, udf_o) are built when the
// macro SCFIFO_CTRL_ERR_FLAGS_EN is defined.
module scfifo_ctrl
  import scfifo_pkg::*;
#(
  parameter int unsigned AWIDTH      = 10,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              ram_wr_en_o,
  output logic [AWIDTH-1:0] ram_wr_addr_o,
  output logic              ram_rd_en_o,
  output logic [AWIDTH-1:0] ram_rd_addr_o,
  output logic              rd_valid_o
`ifdef SCFIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic              ovf_o,
  output logic              udf_o
`endif
);

  if (RAM_LATENCY != LAT_COMB && RAM_LATENCY != LAT_REG) begin : g_bad_latency
    $error("scfifo_ctrl: RAM_LATENCY must be 1 or 2");
  end

  localparam logic [AWIDTH:0] DepthW = {1'b1, {AWIDTH{1'b0}}};

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              wr_acc, rd_acc;
  logic              rd_acc_d1;

  // Request acceptance. A full FIFO still takes a write when a read drains an
  // entry the same cycle; an empty FIFO never lets a read fall through.
  always_comb begin
    rd_acc = ~srst_i & rdreq_i & ~empty_q;
    wr_acc = ~srst_i & wrreq_i & (~full_q | rdreq_i);
  end

  // Next pointers, occupancy and flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AWIDTH'(1);
    usedw_d = (AWIDTH+1)'(calc_next_usedw(32'(usedw_q), wr_acc, rd_acc));
    full_d  = (usedw_d == DepthW);
    empty_d = (usedw_d == '0);
  end

  // Controller state.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  scfifo_rd_pipe #(
    .DEPTH (RAM_LATENCY)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .valid_i (rd_acc),
    .tap1_o  (rd_acc_d1),
    .valid_o (rd_valid_o)
  );

  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign usedw_o       = usedw_q;
  assign ram_wr_en_o   = wr_acc;
  assign ram_wr_addr_o = wr_ptr_q;
  assign ram_rd_addr_o = rd_ptr_q;
  // A registered-output RAM latches its address one cycle before its output
  // register needs enabling.
  assign ram_rd_en_o   = (RAM_LATENCY == LAT_REG) ? rd_acc_d1 : rd_acc;

`ifdef SCFIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags, cleared only by reset.
  always_comb begin
    ovf_d = ovf_q | (wrreq_i & ~wr_acc);
    udf_d = udf_q | (rdreq_i & ~rd_acc);
  end

  // Error flag state.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

endmodule

// File: tb/tb_scfifo_ctrl.sv
// Directed bench for scfifo_ctrl: two 8-deep instances (RAM latency 1 and 2)
// share the same requests, each paired with a behavioural read-before-write RAM.
module tb_scfifo_ctrl;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic [7:0]    wdata = 8'h00;

  logic          full_a, empty_a, wen_a, ren_a, rvalid_a;
  logic [AW:0]   usedw_a;
  logic [AW-1:0] waddr_a, raddr_a;
  logic          full_b, empty_b, wen_b, ren_b, rvalid_b;
  logic [AW:0]   usedw_b;
  logic [AW-1:0] waddr_b, raddr_b;
`ifdef SCFIFO_CTRL_ERR_FLAGS_EN
  logic          ovf_a, udf_a, ovf_b, udf_b;
`endif

  int total = 0;
  int bad   = 0;
  int wp    = 0;
  int rp    = 0;

  always #5 clk = ~clk;

  scfifo_ctrl #(.AWIDTH(AW), .RAM_LATENCY(1)) u_dut_a (
    .clk_i         (clk),
    .srst_i        (srst),
    .wrreq_i       (wrreq),
    .rdreq_i       (rdreq),
    .full_o        (full_a),
    .empty_o       (empty_a),
    .usedw_o       (usedw_a),
    .ram_wr_en_o   (wen_a),
    .ram_wr_addr_o (waddr_a),
    .ram_rd_en_o   (ren_a),
    .ram_rd_addr_o (raddr_a),
    .rd_valid_o    (rvalid_a)
`ifdef SCFIFO_CTRL_ERR_FLAGS_EN
    ,
    .ovf_o         (ovf_a),
    .udf_o         (udf_a)
`endif
  );

  scfifo_ctrl #(.AWIDTH(AW), .RAM_LATENCY(2)) u_dut_b (
    .clk_i         (clk),
    .srst_i        (srst),
    .wrreq_i       (wrreq),
    .rdreq_i       (rdreq),
    .full_o        (full_b),
    .empty_o       (empty_b),
    .usedw_o       (usedw_b),
    .ram_wr_en_o   (wen_b),
    .ram_wr_addr_o (waddr_b),
    .ram_rd_en_o   (ren_b),
    .ram_rd_addr_o (raddr_b),
    .rd_valid_o    (rvalid_b)
`ifdef SCFIFO_CTRL_ERR_FLAGS_EN
    ,
    .ovf_o         (ovf_b),
    .udf_o         (udf_b)
`endif
  );

  // RAM models: synchronous read, old data returned on same-address collision.
  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];
  logic [7:0] rdata_a, rdata_b, mout_b;

  always @(posedge clk) begin
    if (wen_a) mem_a[waddr_a] <= wdata;
    if (ren_a) rdata_a <= mem_a[raddr_a];
  end

  always @(posedge clk) begin
    if (wen_b) mem_b[waddr_b] <= wdata;
    mout_b <= mem_b[raddr_b];
    if (ren_b) rdata_b <= mout_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; wrreq = 1'b0; rdreq = 1'b0;
    step(); step();
    total++; if (usedw_a !== 4'd0) begin bad++; $display("FAIL reset_usedw got=%0d exp=0", usedw_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty_a); end
    total++; if (full_a !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full_a); end
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL reset_rvalid_a got=%b exp=0", rvalid_a); end
    total++; if (rvalid_b !== 1'b0) begin bad++; $display("FAIL reset_rvalid_b got=%b exp=0", rvalid_b); end
    total++; if (wen_a !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", wen_a); end
    total++; if (ren_b !== 1'b0) begin bad++; $display("FAIL reset_ren_b got=%b exp=0", ren_b); end
`ifdef SCFIFO_CTRL_ERR_FLAGS_EN
    total++; if ({ovf_a, udf_a} !== 2'b00) begin bad++; $display("FAIL reset_errflags got=%b exp=00", {ovf_a, udf_a}); end
`endif
    srst = 1'b0; wp = 0; rp = 0;
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      wrreq = 1'b1; wdata = 8'hD0 + 8'(i);
      #1;
      total++; if (wen_a !== 1'b1) begin bad++; $display("FAIL basic_wen i=%0d got=%b exp=1", i, wen_a); end
      total++; if (waddr_a !== 3'(wp)) begin bad++; $display("FAIL basic_waddr i=%0d got=%0d exp=%0d", i, waddr_a, wp % 8); end
      step(); wp++;
      total++; if (usedw_a !== 4'(i + 1)) begin bad++; $display("FAIL basic_usedw_up i=%0d got=%0d exp=%0d", i, usedw_a, i + 1); end
    end
    wrreq = 1'b0; rdreq = 1'b1;
    #1;
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL basic_rvalid_early got=%b exp=0", rvalid_a); end
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ren_a !== 1'b1) begin bad++; $display("FAIL basic_ren i=%0d got=%b exp=1", i, ren_a); end
      total++; if (raddr_a !== 3'(rp)) begin bad++; $display("FAIL basic_raddr i=%0d got=%0d exp=%0d", i, raddr_a, rp % 8); end
      step(); rp++;
      exp = 8'hD0 + 8'(i);
      total++; if (usedw_a !== 4'(3 - i)) begin bad++; $display("FAIL basic_usedw_dn i=%0d got=%0d exp=%0d", i, usedw_a, 3 - i); end
      total++; if (rvalid_a !== 1'b1) begin bad++; $display("FAIL basic_rvalid i=%0d got=%b exp=1", i, rvalid_a); end
      total++; if (rdata_a !== exp) begin bad++; $display("FAIL basic_rdata i=%0d got=%0h exp=%0h", i, rdata_a, exp); end
    end
    rdreq = 1'b0;
    step();
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL basic_rvalid_end got=%b exp=0", rvalid_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL basic_empty_end got=%b exp=1", empty_a); end
  endtask

  task automatic test_full();
    logic [7:0] exp;
    wrreq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdata = 8'hE0 + 8'(i);
      step(); wp++;
    end
    total++; if (full_a !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", full_a); end
    total++; if (usedw_a !== 4'd8) begin bad++; $display("FAIL full_usedw got=%0d exp=8", usedw_a); end
    total++; if (empty_a !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", empty_a); end
    wdata = 8'hEE;
    #1;
    total++; if (wen_a !== 1'b0) begin bad++; $display("FAIL full_reject_wen got=%b exp=0", wen_a); end
    step();
    total++; if (usedw_a !== 4'd8) begin bad++; $display("FAIL full_reject_usedw got=%0d exp=8", usedw_a); end
`ifdef SCFIFO_CTRL_ERR_FLAGS_EN
    total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b exp=1", ovf_a); end
    total++; if (udf_a !== 1'b0) begin bad++; $display("FAIL full_udf got=%b exp=0", udf_a); end
`endif
    // Write and read together while full: both accepted at the same address.
    rdreq = 1'b1; wdata = 8'hAA;
    #1;
    total++; if (wen_a !== 1'b1) begin bad++; $display("FAIL full_wr_rd_wen got=%b exp=1", wen_a); end
    total++; if (ren_a !== 1'b1) begin bad++; $display("FAIL full_wr_rd_ren got=%b exp=1", ren_a); end
    total++; if (waddr_a !== 3'(wp)) begin bad++; $display("FAIL full_wr_rd_waddr got=%0d exp=%0d", waddr_a, wp % 8); end
    total++; if (raddr_a !== 3'(rp)) begin bad++; $display("FAIL full_wr_rd_raddr got=%0d exp=%0d", raddr_a, rp % 8); end
    step(); wp++; rp++;
    total++; if (usedw_a !== 4'd8) begin bad++; $display("FAIL full_wr_rd_usedw got=%0d exp=8", usedw_a); end
    total++; if (full_a !== 1'b1) begin bad++; $display("FAIL full_wr_rd_full got=%b exp=1", full_a); end
    total++; if (rdata_a !== 8'hE0 || rvalid_a !== 1'b1) begin bad++; $display("FAIL full_wr_rd_data got=%0h/%b exp=e0/1", rdata_a, rvalid_a); end
    wrreq = 1'b0;
    #1;
    total++; if (waddr_a !== 3'(wp)) begin bad++; $display("FAIL full_wp_adv got=%0d exp=%0d", waddr_a, wp % 8); end
    total++; if (raddr_a !== 3'(rp)) begin bad++; $display("FAIL full_rp_adv got=%0d exp=%0d", raddr_a, rp % 8); end
    for (int i = 0; i < 8; i++) begin
      step(); rp++;
      exp = (i == 7) ? 8'hAA : 8'hE1 + 8'(i);
      total++; if (rdata_a !== exp || rvalid_a !== 1'b1) begin bad++; $display("FAIL full_drain i=%0d got=%0h/%b exp=%0h/1", i, rdata_a, rvalid_a, exp); end
      if (i == 0) begin
        total++; if (rdata_b !== 8'hE0 || rvalid_b !== 1'b1) begin bad++; $display("FAIL full_rbw_lat2 got=%0h/%b exp=e0/1", rdata_b, rvalid_b); end
      end
    end
    rdreq = 1'b0;
    step();
    total++; if (empty_a !== 1'b1 || full_a !== 1'b0) begin bad++; $display("FAIL full_drained got=e%b f%b exp=e1 f0", empty_a, full_a); end
  endtask

  task automatic test_empty_wr_rd();
    wrreq = 1'b1; rdreq = 1'b1; wdata = 8'h55;
    #1;
    total++; if (wen_a !== 1'b1) begin bad++; $display("FAIL empty_wr_rd_wen got=%b exp=1", wen_a); end
    total++; if (ren_a !== 1'b0) begin bad++; $display("FAIL empty_wr_rd_ren got=%b exp=0", ren_a); end
    step(); wp++;
    total++; if (usedw_a !== 4'd1) begin bad++; $display("FAIL empty_wr_rd_usedw got=%0d exp=1", usedw_a); end
    total++; if (empty_a !== 1'b0) begin bad++; $display("FAIL empty_wr_rd_empty got=%b exp=0", empty_a); end
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL empty_wr_rd_rvalid got=%b exp=0", rvalid_a); end
`ifdef SCFIFO_CTRL_ERR_FLAGS_EN
    total++; if (udf_a !== 1'b1) begin bad++; $display("FAIL empty_udf got=%b exp=1", udf_a); end
`endif
    wrreq = 1'b0; rdreq = 1'b0;
    step();
    total++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL empty_wr_rd_rvalid2 got=%b%b exp=00", rvalid_a, rvalid_b); end
  endtask

  task automatic test_lat2();
    logic       exp_en, exp_v;
    logic [7:0] exp;
    wrreq = 1'b1;
    wdata = 8'h56; step(); wp++;
    wdata = 8'h57; step(); wp++;
    wrreq = 1'b0; rdreq = 1'b1;
    #1;
    total++; if (ren_b !== 1'b0) begin bad++; $display("FAIL lat2_ren_t0 got=%b exp=0", ren_b); end
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= 3) rp++;
      if (k == 3) rdreq = 1'b0;
      exp_en = (k <= 3);
      exp_v  = (k >= 2 && k <= 4);
      exp    = 8'h55 + 8'(k - 2);
      total++; if (ren_b !== exp_en) begin bad++; $display("FAIL lat2_ren k=%0d got=%b exp=%b", k, ren_b, exp_en); end
      total++; if (rvalid_b !== exp_v) begin bad++; $display("FAIL lat2_rvalid k=%0d got=%b exp=%b", k, rvalid_b, exp_v); end
      total++; if (rvalid_a !== exp_en) begin bad++; $display("FAIL lat1_rvalid k=%0d got=%b exp=%b", k, rvalid_a, exp_en); end
      if (exp_v) begin
        total++; if (rdata_b !== exp) begin bad++; $display("FAIL lat2_rdata k=%0d got=%0h exp=%0h", k, rdata_b, exp); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    for (int i = 0; i < 20; i++) begin
      exp = 8'(i * 7 + 3);
      rdreq = 1'b0; wrreq = 1'b1; wdata = exp;
      #1;
      total++; if (waddr_a !== 3'(wp)) begin bad++; $display("FAIL wrap_waddr i=%0d got=%0d exp=%0d", i, waddr_a, wp % 8); end
      step(); wp++;
      wrreq = 1'b0; rdreq = 1'b1;
      #1;
      total++; if (raddr_a !== 3'(rp)) begin bad++; $display("FAIL wrap_raddr i=%0d got=%0d exp=%0d", i, raddr_a, rp % 8); end
      step(); rp++;
      total++; if (rdata_a !== exp || rvalid_a !== 1'b1) begin bad++; $display("FAIL wrap_rdata i=%0d got=%0h/%b exp=%0h/1", i, rdata_a, rvalid_a, exp); end
      total++; if (usedw_a !== 4'd0) begin bad++; $display("FAIL wrap_usedw i=%0d got=%0d exp=0", i, usedw_a); end
    end
    rdreq = 1'b0;
  endtask

  task automatic test_reset_mid();
    wrreq = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wdata = 8'h30 + 8'(i);
      step();
    end
    wrreq = 1'b0; rdreq = 1'b1;
    step(); step();
    total++; if (usedw_a !== 4'd5) begin bad++; $display("FAIL rstmid_pre_usedw got=%0d exp=5", usedw_a); end
    rdreq = 1'b0; srst = 1'b1;
    step();
    total++; if (usedw_a !== 4'd0) begin bad++; $display("FAIL rstmid_usedw got=%0d exp=0", usedw_a); end
    total++; if (empty_a !== 1'b1 || full_a !== 1'b0) begin bad++; $display("FAIL rstmid_flags got=e%b f%b exp=e1 f0", empty_a, full_a); end
    total++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL rstmid_rvalid got=%b%b exp=00", rvalid_a, rvalid_b); end
    total++; if (ren_b !== 1'b0) begin bad++; $display("FAIL rstmid_ren_b got=%b exp=0", ren_b); end
    srst = 1'b0; wp = 0; rp = 0;
    wrreq = 1'b1; wdata = 8'h99;
    #1;
    total++; if (waddr_a !== 3'd0) begin bad++; $display("FAIL rstmid_waddr got=%0d exp=0", waddr_a); end
    total++; if (rvalid_b !== 1'b0) begin bad++; $display("FAIL rstmid_inflight_b got=%b exp=0", rvalid_b); end
`ifdef SCFIFO_CTRL_ERR_FLAGS_EN
    total++; if ({ovf_a, udf_a} !== 2'b00) begin bad++; $display("FAIL rstmid_errflags got=%b exp=00", {ovf_a, udf_a}); end
`endif
    step(); wp++;
    wrreq = 1'b0; rdreq = 1'b1;
    #1;
    total++; if (raddr_a !== 3'd0 || ren_a !== 1'b1) begin bad++; $display("FAIL rstmid_raddr got=%0d/%b exp=0/1", raddr_a, ren_a); end
    step(); rp++;
    rdreq = 1'b0;
    total++; if (rdata_a !== 8'h99 || rvalid_a !== 1'b1) begin bad++; $display("FAIL rstmid_rdata_a got=%0h/%b exp=99/1", rdata_a, rvalid_a); end
    step();
    total++; if (rdata_b !== 8'h99 || rvalid_b !== 1'b1) begin bad++; $display("FAIL rstmid_rdata_b got=%0h/%b exp=99/1", rdata_b, rvalid_b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_empty_wr_rd();
    test_lat2();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
